bus_xfer_sequencer: RTL
=======================

Name: bus_xfer_sequencer

Overview:
- Parametrised control-word sequencer for the CPU datapath bus fabric. It replaces the static control-bus word with a queued, timed transfer engine.
- Accepts transfer commands (ALU opcode, data-bus master ID, data-bus slave ID, address-bus master ID, PC increment flag, repeat count) through a valid/ready FIFO.
- Plays each command out as a three-phase T-state sequence, driving one-hot OE/WE/address-OE vectors to the registers, ALU, RAM and ports.

Parameters:
- N_MASTERS, 19, number of data-bus master OE lines (IDs 0..18: IR0, IR1, A, B, M, R0, R1, AR0, AR1, PC0, PC1, SP0, SP1, PORTA..D, SR, ALU).
- N_SLAVES, 17, number of data-bus slave WE lines (IDs 0..16, same ordering as masters 0..16).
- N_AMASTERS, 4, number of address-bus master lines (0 PC, 1 AR, 2 SP, 3 R0R1).
- ID_W, 5, width of MID/SID fields.
- AID_W, 2, width of AMID field.
- OPC_W, 5, ALU opcode width.
- CNT_W, 4, repeat-count width.
- FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hlt  in  1  freeze sequencing
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_data  in  CMD_W  {opcode[OPC_W], mid[ID_W], sid[ID_W], amid[AID_W], pc_inr, rep[CNT_W]}; CMD_W = OPC_W+2*ID_W+AID_W+1+CNT_W (22 by default)
- oe  out  N_MASTERS  one-hot data-bus master output enables
- we  out  N_SLAVES  one-hot data-bus slave write enables
- aoe  out  N_AMASTERS  one-hot address-bus master enables
- alu_opcode  out  OPC_W  opcode of the current command
- pc_inr  out  1  PC count enable
- T  out  4  one-hot timing state
- busy  out  1  high when not IDLE or FIFO non-empty
- done  out  1  one-cycle pulse at the end of each command's last HOLD
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: FIFO empty, state IDLE, oe/we/aoe/alu_opcode/pc_inr/done/err all 0, T=4'b1000, busy=0, cmd_ready=1.
- FIFO push: occurs on a cmd_valid & cmd_ready edge. Push and pop in the same cycle is legal and leaves the count unchanged.
- FSM states and T encoding:
  - IDLE (T=1000)
  - SETUP (T=0001)
  - STROBE (T=0010)
  - HOLD (T=0100)
- IDLE: if the FIFO is non-empty, pop into the current-command register and go to SETUP.
  - Command pushed into an empty FIFO at edge k → popped at edge k+1 → SETUP visible after edge k+1.
- SETUP: oe[mid] and aoe[amid] asserted, alu_opcode driven, we=0. Next state STROBE.
- STROBE: oe and aoe held, we[sid]=1 for exactly one cycle, pc_inr=cmd.pc_inr. Next state HOLD.
- HOLD: oe and aoe held, we=0, pc_inr=0.
  - If rep_left≠0: decrement rep_left, go to SETUP.
  - Else: pulse done. If the FIFO is non-empty, pop and go to SETUP (back-to-back with no IDLE cycle); otherwise go to IDLE.
- Repeat count: a command executes rep+1 transfers (rep=0 → one transfer). rep_left is loaded on pop.
- Out-of-range IDs: mid>=N_MASTERS, sid>=N_SLAVES or amid>=N_AMASTERS produce no asserted bit on that vector; the timing still runs.
- Outputs: oe/we/aoe/alu_opcode/pc_inr are decoded from registered state plus the command register, so no combinational path from cmd_*.
- hlt=1:
  - State, rep_left and the FIFO read side freeze.
  - we and pc_inr are forced to 0; oe, aoe and T hold.
  - Pushes are still accepted.
  - After hlt falls in STROBE, we asserts for exactly one cycle.
- Reset mid-operation: all outputs are at reset values after the reset edge. The in-flight command and the queued commands are discarded.
- Outside IDLE, exactly one oe bit, at most one we bit and one aoe bit are asserted.

Optional Feature:
- Macro: BUS_CHECK_EN.
- Defined:
  - On pop, the command is checked for mid==sid (same register, IDs <17), mid>=N_MASTERS, sid>=N_SLAVES, or amid>=N_AMASTERS.
  - An illegal command is dropped: no SETUP/STROBE/HOLD, no done, and the next entry is popped the following cycle.
  - err is set and stays set until reset.
- Undefined: no checking logic, err is tied to 0, and illegal commands execute as described under out-of-range IDs.

Test Plan:
- Reset, then push {op=3, mid=2(A), sid=4(M), amid=1(AR), pc_inr=0, rep=0} → T sequence 0001,0010,0100; oe=bit2 for 3 cycles, aoe=bit1, we=bit4 only in STROBE, done pulses at the end of HOLD, then T=1000.
- Push 5 commands back-to-back with cmd_valid held → cmd_ready drops after 4 stored (one may already be popped: verify the count), all 5 execute in order with no IDLE between them, and done pulses 5 times.
- Command mid=9(PC0), sid=0(IR0), amid=0, pc_inr=1, rep=2 → 3 transfers and 3 pc_inr pulses, each coincident with we[0].
- hlt raised in STROBE for 4 cycles → we=0 and pc_inr=0 while halted, oe held; after release we is high for exactly one cycle.
- Reset asserted during HOLD with 2 commands queued → next cycle oe=we=aoe=0, T=1000, busy=0, cmd_ready=1, and no further done.
- With BUS_CHECK_EN: command mid=5, sid=5 → dropped, err=1 and stays 1; a following legal command executes normally. Without the macro, err remains 0.

Source files
------------

// File: rtl/bus_xfer_sequencer.sv
// Queued control-word sequencer: plays each command out as SETUP/STROBE/HOLD T-states.
// Optional command legality checking is enabled by defining BUS_CHECK_EN.
module bus_xfer_sequencer #(
  parameter int unsigned N_MASTERS  = 19,
  parameter int unsigned N_SLAVES   = 17,
  parameter int unsigned N_AMASTERS = 4,
  parameter int unsigned ID_W       = 5,
  parameter int unsigned AID_W      = 2,
  parameter int unsigned OPC_W      = 5,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CMD_W     = OPC_W + 2*ID_W + AID_W + 1 + CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hlt,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_W-1:0]      cmd_data,
  output logic [N_MASTERS-1:0]  oe,
  output logic [N_SLAVES-1:0]   we,
  output logic [N_AMASTERS-1:0] aoe,
  output logic [OPC_W-1:0]      alu_opcode,
  output logic                  pc_inr,
  output logic [3:0]            T,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned REP_LSB  = 0;
  localparam int unsigned PC_LSB   = CNT_W;
  localparam int unsigned AMID_LSB = CNT_W + 1;
  localparam int unsigned SID_LSB  = AMID_LSB + AID_W;
  localparam int unsigned MID_LSB  = SID_LSB + ID_W;
  localparam int unsigned OPC_LSB  = MID_LSB + ID_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [CMD_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              full, empty, push, pop, drop, rep_dec, illegal_c;
  logic [CMD_W-1:0]  head;

  logic [1:0]        state, state_nxt;
  logic [OPC_W-1:0]  cur_opc;
  logic [ID_W-1:0]   cur_mid, cur_sid;
  logic [AID_W-1:0]  cur_amid;
  logic              cur_pc;
  logic [CNT_W-1:0]  rep_left;
  logic              strobe_go;

  assign full      = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign empty     = (fifo_cnt == '0);
  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state != S_IDLE) || !empty;
  assign done      = (state == S_HOLD) && !hlt && (rep_left == '0);
  assign strobe_go = (state == S_STROBE) && !hlt;

`ifdef BUS_CHECK_EN
  logic err_q;

  // Same register on both sides of the bus, or any ID with no matching line
  assign illegal_c = (head[MID_LSB +: ID_W] == head[SID_LSB +: ID_W])
                  || (32'(head[MID_LSB +: ID_W]) >= N_MASTERS)
                  || (32'(head[SID_LSB +: ID_W]) >= N_SLAVES)
                  || (32'(head[AMID_LSB +: AID_W]) >= N_AMASTERS);

  always_ff @(posedge clk) begin
    if (reset)              err_q <= 1'b0;
    else if (pop && drop)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign illegal_c = 1'b0;
  assign err       = 1'b0;
`endif

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; hlt freezes the sequence and the FIFO read side
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drop      = 1'b0;
    rep_dec   = 1'b0;
    if (!hlt) begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            pop  = 1'b1;
            drop = illegal_c;
            if (!illegal_c) state_nxt = S_SETUP;
          end
        end
        S_SETUP:  state_nxt = S_STROBE;
        S_STROBE: state_nxt = S_HOLD;
        default: begin
          if (rep_left != '0) begin
            rep_dec   = 1'b1;
            state_nxt = S_SETUP;
          end else if (!empty) begin
            pop       = 1'b1;
            drop      = illegal_c;
            state_nxt = illegal_c ? S_IDLE : S_SETUP;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  // Current-command register and repeat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_opc  <= '0;
      cur_mid  <= '0;
      cur_sid  <= '0;
      cur_amid <= '0;
      cur_pc   <= 1'b0;
      rep_left <= '0;
    end else if (pop && !drop) begin
      cur_opc  <= head[OPC_LSB +: OPC_W];
      cur_mid  <= head[MID_LSB +: ID_W];
      cur_sid  <= head[SID_LSB +: ID_W];
      cur_amid <= head[AMID_LSB +: AID_W];
      cur_pc   <= head[PC_LSB];
      rep_left <= head[REP_LSB +: CNT_W];
    end else if (rep_dec) begin
      rep_left <= rep_left - CNT_W'(1);
    end
  end

  // One-hot bus control decode from registered state and command
  always_comb begin
    oe         = '0;
    we         = '0;
    aoe        = '0;
    alu_opcode = '0;
    pc_inr     = 1'b0;
    case (state)
      S_SETUP:  T = 4'b0001;
      S_STROBE: T = 4'b0010;
      S_HOLD:   T = 4'b0100;
      default:  T = 4'b1000;
    endcase
    if (state != S_IDLE) begin
      alu_opcode = cur_opc;
      pc_inr     = strobe_go && cur_pc;
      for (int i = 0; i < N_MASTERS; i++)  oe[i]  = (cur_mid == ID_W'(i));
      for (int i = 0; i < N_SLAVES; i++)   we[i]  = strobe_go && (cur_sid == ID_W'(i));
      for (int i = 0; i < N_AMASTERS; i++) aoe[i] = (cur_amid == AID_W'(i));
    end
  end

endmodule
